// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: three-stage floating-point adder/subtractor for a generic
// {sign, exponent, fraction} format (bfloat16 by default). Subnormal inputs
// and results are flushed to zero, rounding is round-to-nearest-even, and a
// single global stall holds every stage while the output is not accepted.
module fp_addsub_pipe #(
   parameter  int EXP_W = 8,
   parameter  int MAN_W = 7,
   parameter  int TAG_W = 4,
   localparam int W     = 1 + EXP_W + MAN_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic             op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     result,
   output logic [3:0]       flags,
   output logic [TAG_W-1:0] out_tag
);

   // Working mantissa is {hidden, fraction, guard, round, sticky}.
   localparam int L      = MAN_W + 4;
   localparam int SH_MAX = MAN_W + 3;
   localparam int SH_W   = $clog2(SH_MAX + 1);
   localparam int LZ_W   = $clog2(L + 1);
   localparam int EW2    = EXP_W + LZ_W + 2;
   localparam int EMAX   = (1 << EXP_W) - 1;

   localparam logic signed [EW2-1:0] E_MAX  = EW2'(EMAX);
   localparam logic signed [EW2-1:0] E_ZERO = '0;
   localparam logic signed [EW2-1:0] E_ONE  = EW2'(1);
   localparam logic [W-1:0]          QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   // Leading-zero count of the working mantissa (L when all zero).
   function automatic logic [LZ_W-1:0] lzc(input logic [L-1:0] v);
      logic [LZ_W-1:0] n;
      logic            found;
      n     = '0;
      found = 1'b0;
      for (int i = L - 1; i >= 0; i--) begin
         if (!found && !v[i]) n = n + LZ_W'(1);
         else                 found = 1'b1;
      end
      return n;
   endfunction

   // Round-to-nearest-even on {1, frac}; the top bit is the rounding carry.
   function automatic logic [MAN_W+1:0] rne(input logic [L-1:0] m);
      logic up;
      up = m[2] & (m[1] | m[0] | m[3]);
      return {1'b0, m[L-1:3]} + {{(MAN_W+1){1'b0}}, up};
   endfunction

   // Round, then saturate to Inf or flush to zero; returns {flags, word}.
   function automatic logic [W+3:0] pack(input logic s,
                                         input logic signed [EW2-1:0] e,
                                         input logic [L-1:0] m);
      logic [MAN_W+1:0]      r;
      logic [MAN_W-1:0]      frac;
      logic signed [EW2-1:0] er;
      logic                  inex;
      r    = rne(m);
      inex = |m[2:0];
      er   = e + $signed({{(EW2-1){1'b0}}, r[MAN_W+1]});
      frac = r[MAN_W+1] ? r[MAN_W:1] : r[MAN_W-1:0];
      if (er >= E_MAX)
         pack = {4'b0101, s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else if (er <= E_ZERO)
         pack = {4'b0011, s, {(W-1){1'b0}}};
      else
         pack = {3'b000, inex, s, er[EXP_W-1:0], frac};
   endfunction

   logic adv;
   logic vld_p0, vld_p1, vld_p2;

   assign adv       = out_ready | ~out_valid;
   assign in_ready  = adv;
   assign out_valid = vld_p2;

   // ---------------- stage 0: unpack, classify, swap, align ----------------
   logic               sa, sbe, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_ge_b;
   logic [EXP_W-1:0]   ea, eb;
   logic [MAN_W-1:0]   fa, fb;

   assign sa     = a[W-1];
   assign sbe    = b[W-1] ^ op;
   assign ea     = a[W-2:MAN_W];
   assign eb     = b[W-2:MAN_W];
   assign a_zero = (ea == '0);
   assign b_zero = (eb == '0);
   assign fa     = a_zero ? '0 : a[MAN_W-1:0];
   assign fb     = b_zero ? '0 : b[MAN_W-1:0];
   assign a_inf  = (&ea) & ~(|fa);
   assign b_inf  = (&eb) & ~(|fb);
   assign a_nan  = (&ea) & (|fa);
   assign b_nan  = (&eb) & (|fb);
   assign a_ge_b = ({ea, fa} >= {eb, fb});

   logic               x_s, y_s, x_z, y_z;
   logic [EXP_W-1:0]   x_e, y_e, diff;
   logic [MAN_W-1:0]   x_f, y_f;
   logic [SH_W-1:0]    sh;
   logic [L-1:0]       mx, my, y_m;
   logic [2*L-1:0]     y_ext;

   // Order operands by magnitude and shift the smaller one into alignment.
   always_comb begin
      x_s = sa;   x_e = ea;   x_f = fa;   x_z = a_zero;
      y_s = sbe;  y_e = eb;   y_f = fb;   y_z = b_zero;
      if (!a_ge_b) begin
         x_s = sbe;  x_e = eb;  x_f = fb;  x_z = b_zero;
         y_s = sa;   y_e = ea;  y_f = fa;  y_z = a_zero;
      end
      diff = x_e - y_e;
      if (32'(diff) > SH_MAX) sh = SH_W'(SH_MAX);
      else                    sh = SH_W'(diff);
      y_m   = {~y_z, y_f, 3'b000};
      y_ext = {y_m, {L{1'b0}}} >> sh;
      my    = {y_ext[2*L-1:L+1], y_ext[L] | (|y_ext[L-1:0])};
      mx    = {~x_z, x_f, 3'b000};
   end

   logic               spec, spec_inv;
   logic [W-1:0]       spec_res;

   // Special operands bypass the arithmetic path entirely.
   always_comb begin
      spec     = a_nan | b_nan | a_inf | b_inf | (a_zero & b_zero);
      spec_inv = 1'b0;
      spec_res = {sa & sbe, {(W-1){1'b0}}};
      if (a_nan | b_nan | (a_inf & b_inf & (sa ^ sbe))) begin
         spec_res = QNAN;
         spec_inv = 1'b1;
      end else if (a_inf) begin
         spec_res = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (b_inf) begin
         spec_res = {sbe, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end
   end

   logic               sgn_p0, sub_p0, spec_p0, inv_p0;
   logic [EXP_W-1:0]   exp_p0;
   logic [L-1:0]       mx_p0, my_p0;
   logic [W-1:0]       sres_p0;
   logic [TAG_W-1:0]   tag_p0;

   // Stage-0 data register; loads on every advance, bubbles included.
   always_ff @(posedge clk) begin
      if (adv) begin
         sgn_p0  <= x_s;
         sub_p0  <= x_s ^ y_s;
         exp_p0  <= x_e;
         mx_p0   <= mx;
         my_p0   <= my;
         spec_p0 <= spec;
         inv_p0  <= spec_inv;
         sres_p0 <= spec_res;
         tag_p0  <= in_tag;
      end
   end

   // ---------------- stage 1: add/subtract and normalise -------------------
   logic [L:0]            sum;
   logic [LZ_W-1:0]       lz;
   logic [L-1:0]          nm;
   logic signed [EW2-1:0] ne, exp_ext, lz_ext;
   logic                  nz;

   // Magnitude add or subtract; X >= Y so the difference never goes negative.
   always_comb begin
      sum     = sub_p0 ? ({1'b0, mx_p0} - {1'b0, my_p0})
                       : ({1'b0, mx_p0} + {1'b0, my_p0});
      lz      = lzc(sum[L-1:0]);
      exp_ext = $signed({{(EW2-EXP_W){1'b0}}, exp_p0});
      lz_ext  = $signed({{(EW2-LZ_W){1'b0}}, lz});
      nz      = (sum == '0);
      if (sum[L]) begin
         nm = {sum[L:2], sum[1] | sum[0]};
         ne = exp_ext + E_ONE;
      end else begin
         nm = sum[L-1:0] << lz;
         ne = exp_ext - lz_ext;
      end
   end

   logic                  sgn_p1, zero_p1, spec_p1, inv_p1;
   logic signed [EW2-1:0] exp_p1;
   logic [L-1:0]          man_p1;
   logic [W-1:0]          sres_p1;
   logic [TAG_W-1:0]      tag_p1;

   // Stage-1 data register.
   always_ff @(posedge clk) begin
      if (adv) begin
         sgn_p1  <= sgn_p0;
         zero_p1 <= nz;
         exp_p1  <= ne;
         man_p1  <= nm;
         spec_p1 <= spec_p0;
         inv_p1  <= inv_p0;
         sres_p1 <= sres_p0;
         tag_p1  <= tag_p0;
      end
   end

   // ---------------- stage 2: round, pack, select specials -----------------
   logic [W+3:0] out_nxt;

   // Exact cancellation yields +0 with no flags; specials override all.
   always_comb begin
      out_nxt = pack(sgn_p1, exp_p1, man_p1);
      if (spec_p1)      out_nxt = {inv_p1, 3'b000, sres_p1};
      else if (zero_p1) out_nxt = '0;
   end

   // Output register; cleared by reset so a stale result is never visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result  <= '0;
         flags   <= '0;
         out_tag <= '0;
      end else if (adv) begin
         result  <= out_nxt[W-1:0];
         flags   <= out_nxt[W+3:W];
         out_tag <= tag_p1;
      end
   end

   // Valid bits travel with the data and freeze during a stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else if (adv) begin
         vld_p0 <= in_valid;
         vld_p1 <= vld_p0;
         vld_p2 <= vld_p1;
      end
   end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe: directed cases, backpressure, mid-stream reset,
// and a randomized stream checked against an exact-arithmetic model.
module tb_fp_addsub_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        in_valid, in_ready, op, out_valid, out_ready;
   logic [15:0] a, b, result;
   logic [3:0]  flags, in_tag, out_tag;

   logic        hf_in_valid, hf_in_ready, hf_op, hf_out_valid;
   logic [15:0] hf_a, hf_b, hf_result;
   logic [3:0]  hf_flags, hf_in_tag, hf_out_tag;

   fp_addsub_pipe dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .in_tag(in_tag), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .flags(flags), .out_tag(out_tag));

   fp_addsub_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut_hf (
      .clk(clk), .rst_n(rst_n), .in_valid(hf_in_valid), .in_ready(hf_in_ready),
      .a(hf_a), .b(hf_b), .op(hf_op), .in_tag(hf_in_tag), .out_valid(hf_out_valid),
      .out_ready(1'b1), .result(hf_result), .flags(hf_flags), .out_tag(hf_out_tag));

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   // Exact reference: operands become integers in units of the smallest
   // normal ulp, are summed exactly, then rounded RNE and range-checked.
   function automatic logic [35:0] ref_op(input int ew, input int mw,
                                          input logic [31:0] x, input logic [31:0] y,
                                          input logic o);
      int emax, ex, ey, fx, fy, p, e, sh;
      logic sx, sy, s, inexact;
      logic [31:0] qnan, word;
      logic [299:0] vx, vy, mag, kept, rem, half;
      emax = (1 << ew) - 1;
      sx = x[ew+mw];
      sy = y[ew+mw] ^ o;
      ex = int'(x >> mw) & emax;
      ey = int'(y >> mw) & emax;
      fx = (ex == 0) ? 0 : int'(x) & ((1 << mw) - 1);
      fy = (ey == 0) ? 0 : int'(y) & ((1 << mw) - 1);
      qnan = 32'((emax << mw) | (1 << (mw - 1)));
      if ((ex == emax && fx != 0) || (ey == emax && fy != 0)) return {4'b1000, qnan};
      if (ex == emax && ey == emax && sx != sy) return {4'b1000, qnan};
      if (ex == emax) return {4'b0000, (32'(sx) << (ew + mw)) | 32'(emax << mw)};
      if (ey == emax) return {4'b0000, (32'(sy) << (ew + mw)) | 32'(emax << mw)};
      if (ex == 0 && ey == 0) return {4'b0000, 32'(sx & sy) << (ew + mw)};
      vx = (ex == 0) ? '0 : (300'((1 << mw) | fx) << (ex - 1));
      vy = (ey == 0) ? '0 : (300'((1 << mw) | fy) << (ey - 1));
      if (sx == sy)      begin mag = vx + vy; s = sx; end
      else if (vx >= vy) begin mag = vx - vy; s = sx; end
      else               begin mag = vy - vx; s = sy; end
      if (mag == '0) return '0;
      p = 0;
      for (int i = 0; i < 300; i++) if (mag[i]) p = i;
      if (p > mw) begin
         sh = p - mw;
         kept = mag >> sh;
         rem = mag - (kept << sh);
         half = 300'(1) << (sh - 1);
         inexact = (rem != '0);
         if (rem > half || (rem == half && kept[0])) kept = kept + 1;
         if (kept[mw+1]) begin kept = kept >> 1; p++; end
      end else begin
         kept = mag << (mw - p);
         inexact = 1'b0;
      end
      e = p - mw + 1;
      if (e >= emax) return {4'b0101, (32'(s) << (ew + mw)) | 32'(emax << mw)};
      if (e <= 0) return {4'b0011, 32'(s) << (ew + mw)};
      word = (32'(s) << (ew + mw)) | 32'(e << mw) | (kept[31:0] & 32'((1 << mw) - 1));
      return {3'b000, inexact, word};
   endfunction

   function automatic logic [31:0] rnd_word(input int ew, input int mw);
      int emax, e, f, s;
      emax = (1 << ew) - 1;
      s = int'($urandom_range(0, 1));
      e = int'($urandom_range(0, emax));
      f = int'($urandom_range(0, (1 << mw) - 1));
      case ($urandom_range(0, 11))
         0: begin e = emax; f = 0; end
         1: begin e = emax; f = f | 1; end
         2: e = 0;
         3: e = emax - 1;
         4: e = 1;
         default: ;
      endcase
      return 32'((s << (ew + mw)) | (e << mw) | f);
   endfunction

   // Operand pairs, often with nearby exponents to provoke cancellation.
   task automatic rnd_pair(input int ew, input int mw, output logic [31:0] x, output logic [31:0] y);
      int emax, e;
      emax = (1 << ew) - 1;
      x = rnd_word(ew, mw);
      y = rnd_word(ew, mw);
      if ($urandom_range(0, 1) == 1) begin
         e = (int'(x >> mw) & emax) + int'($urandom_range(0, 4)) - 2;
         if (e < 1) e = 1;
         if (e > emax - 1) e = emax - 1;
         y = (y & ~32'(emax << mw)) | 32'(e << mw);
      end
   endtask

   typedef struct {
      logic [15:0] res;
      logic [3:0]  fl;
      logic [3:0]  tag;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        cur_exp;
   logic        last_acc, held;
   logic [23:0] hold_val;
   int          n_out = 0;

   // One clock of the bf16 port: inspect mid-cycle, then advance past posedge.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (held) begin
         check("hold_valid", out_valid, 1);
         check("hold_data", {out_tag, flags, result}, hold_val);
      end
      if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
      if (!out_valid) check("idle_in_ready", in_ready, 1);
      last_acc = in_valid && in_ready;
      if (last_acc) exp_q.push_back(cur_exp);
      if (out_valid && out_ready) begin
         n_out++;
         check("out_has_op", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("result", {out_tag, flags, result}, {e.tag, e.fl, e.res});
         end
      end
      held = out_valid && !out_ready;
      hold_val = {out_tag, flags, result};
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 100 && exp_q.size() > 0; i++) tick();
      check("drain_empty", exp_q.size(), 0);
   endtask

   task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic o,
                        input logic [15:0] r, input logic [3:0] f);
      a = x; b = y; op = o; in_tag = 4'($urandom);
      cur_exp = '{r, f, in_tag};
      in_valid = 1'b1;
      out_ready = 1'b1;
      last_acc = 1'b0;
      for (int i = 0; i < 20 && !last_acc; i++) tick();
      check("issue_accepted", last_acc, 1);
      in_valid = 1'b0;
   endtask

   task automatic gen_op(input logic [3:0] t);
      logic [31:0] x, y;
      logic [35:0] r;
      rnd_pair(8, 7, x, y);
      a = x[15:0]; b = y[15:0]; op = 1'($urandom); in_tag = t;
      r = ref_op(8, 7, {16'h0, a}, {16'h0, b}, op);
      cur_exp = '{r[15:0], r[35:32], t};
   endtask

   task automatic hf_run(input logic [15:0] x, input logic [15:0] y, input logic o,
                         input logic [15:0] r, input logic [3:0] f);
      int w;
      logic [3:0] t;
      hf_a = x; hf_b = y; hf_op = o; hf_in_tag = 4'($urandom); t = hf_in_tag;
      hf_in_valid = 1'b1;
      check("hf_in_ready", hf_in_ready, 1);
      @(posedge clk); #1;
      hf_in_valid = 1'b0;
      w = 0;
      while (!hf_out_valid && w < 10) begin @(posedge clk); #1; w++; end
      check("hf_latency", w, 2);
      check("hf_result", {hf_out_tag, hf_flags, hf_result}, {t, f, r});
      @(posedge clk); #1;
   endtask

   initial begin
      int sent, n0, seen;
      logic [31:0] x, y;
      logic [35:0] r;
      logic o;
      rst_n = 1'b0;
      in_valid = 0; a = 0; b = 0; op = 0; in_tag = 0; out_ready = 1;
      hf_in_valid = 0; hf_a = 0; hf_b = 0; hf_op = 0; hf_in_tag = 0;
      held = 0; last_acc = 0; cur_exp = '{16'h0, 4'h0, 4'h0};
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_outputs", {out_tag, flags, result}, 0);
      check("rst_in_ready", in_ready, 1);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed arithmetic and special cases, default format.
      issue(16'h4188, 16'hC188, 1, 16'h4208, 4'h0);
      issue(16'h40E0, 16'h4020, 1, 16'h4090, 4'h0);
      issue(16'h3F80, 16'hBF80, 0, 16'h0000, 4'h0);
      issue(16'h3F80, 16'h3B80, 0, 16'h3F80, 4'h1);
      issue(16'h3F81, 16'h3B80, 0, 16'h3F82, 4'h1);
      issue(16'h7F7F, 16'h7F7F, 0, 16'h7F80, 4'h5);
      issue(16'h7F80, 16'h7F80, 1, 16'h7FC0, 4'h8);
      issue(16'h7FC1, 16'h3F80, 0, 16'h7FC0, 4'h8);
      issue(16'h8000, 16'h8000, 0, 16'h8000, 4'h0);
      issue(16'h8000, 16'h0000, 1, 16'h8000, 4'h0);
      issue(16'h0080, 16'h0081, 1, 16'h8000, 4'h3);
      issue(16'h0001, 16'h3F80, 0, 16'h3F80, 4'h0);
      issue(16'hFF80, 16'h3F80, 0, 16'hFF80, 4'h0);
      drain();

      // Six back-to-back tagged ops with the consumer stalled in cycles 4..8.
      n0 = n_out;
      sent = 0;
      gen_op(4'(sent));
      for (int c = 1; c <= 40 && (sent < 6 || exp_q.size() > 0); c++) begin
         in_valid = (sent < 6);
         out_ready = !(c >= 4 && c <= 8);
         tick();
         if (last_acc) begin sent++; gen_op(4'(sent)); end
      end
      in_valid = 1'b0;
      drain();
      check("bp_sent", sent, 6);
      check("bp_out_count", n_out - n0, 6);

      // Randomized stream with random input gaps and output stalls.
      sent = 0;
      gen_op(4'($urandom));
      for (int c = 0; c < 2000 && sent < 400; c++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
         if (last_acc) begin sent++; gen_op(4'($urandom)); end
      end
      drain();
      check("random_sent", sent, 400);

      // Reset with three ops in flight and the output stalled.
      out_ready = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a = 16'h4188; b = 16'h3F80; op = 0; in_tag = 4'(i + 1);
         cur_exp = '{16'h0, 4'h0, 4'h0};
         tick();
      end
      in_valid = 1'b0;
      check("pre_reset_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_outputs", {out_tag, flags, result}, 0);
      check("mid_rst_in_ready", in_ready, 1);
      exp_q.delete();
      held = 1'b0;
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      out_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin @(posedge clk); #1; if (out_valid) seen++; end
      check("post_reset_quiet", seen, 0);
      a = 16'h3F80; b = 16'h3F80; op = 0; in_tag = 4'hA; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("lat_cycle1", out_valid, 0);
      @(posedge clk); #1;
      check("lat_cycle2", out_valid, 0);
      @(posedge clk); #1;
      check("lat_cycle3", out_valid, 1);
      check("lat_result", {out_tag, flags, result}, {4'hA, 4'h0, 16'h4000});
      @(posedge clk); #1;
      check("lat_consumed", out_valid, 0);

      // Half-precision instance.
      hf_run(16'h3C00, 16'h3C00, 0, 16'h4000, 4'h0);
      for (int i = 0; i < 40; i++) begin
         rnd_pair(5, 10, x, y);
         o = 1'($urandom);
         r = ref_op(5, 10, x, y, o);
         hf_run(x[15:0], y[15:0], o, r[15:0], r[35:32]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fp_addsub_pipe.md
# fp_addsub_pipe

Parametrised, pipelined floating-point adder/subtractor with a valid/ready handshake on both sides. It generalises the combinational bfloat16 add/sub to any sign/exponent/fraction format (bfloat16 by default) and to a 3-stage pipeline. It adds round-to-nearest-even, IEEE-style special-value handling, exception flags, a pass-through tag and output backpressure. It sits between the operand-fetch logic and the result writeback of the BF16 datapath.

## Interface
- EXP_W, 8, exponent field width (≥3); bias = 2^(EXP_W-1)-1
- MAN_W, 7, stored fraction width (≥2); word width W = 1+EXP_W+MAN_W
- TAG_W, 4, width of sideband tag carried alongside each operation
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous and active-low
- in_valid  input  1  operand pair presented
- in_ready  output  1  block accepts operands this cycle
- a  input  W  operand A, {sign, exponent, fraction}
- b  input  W  operand B
- op  input  1  0 = A+B, 1 = A−B
- in_tag  input  TAG_W  sideband, returned unchanged with the result
- out_valid  output  1  result presented
- out_ready  input  1  consumer accepts result this cycle
- result  output  W  rounded sum/difference
- flags  output  4  {invalid, overflow, underflow, inexact}
- out_tag  output  TAG_W  tag of the operation in result

## Operation
- Transfer in when in_valid&&in_ready; transfer out when out_valid&&out_ready.
- Global stall: adv = out_ready || !out_valid; in_ready = adv (combinational). All stage registers load only when adv=1; each stage carries a valid bit, bubbles are not compacted.
- S1 unpack: bias-relative exponents. Subnormal inputs (exp=0, frac≠0) are flushed to ±0 (FTZ). Effective sign of B = b.sign ^ op. Detect NaN/Inf/zero. Swap so that |X| ≥ |Y| (compare exponent, then fraction). Align Y right by min(expX−expY, MAN_W+3), keeping guard, round and sticky (OR of all shifted-out bits).
- S2 add: mantissas {1,frac,G,R,S} (MAN_W+4 bits, +1 carry). Sign of result = sign of X. Effective subtract when signs differ. Normalise: carry-out → shift right 1, sticky keeps the dropped bit, exp+1. Otherwise a leading-zero count shifts left, exp−lzc.
- S3 round/pack: RNE. Round up when G && (R||S||lsb). Mantissa overflow from rounding → exp+1. inexact = G||R||S before rounding.
- Exponent ≥ 2^EXP_W−1 after rounding → ±Inf, overflow=1, inexact=1.
- Exponent ≤ 0 → ±0, underflow=1, inexact=1 (FTZ output).
- Exact zero from effective subtract → +0, all flags 0. (−0)+(−0) → −0.
- Specials override arithmetic. Any NaN input → canonical qNaN (sign 0, exp all-ones, frac MSB 1, rest 0), invalid=1. Inf−Inf (effective) → canonical qNaN, invalid=1. Inf ± finite → that Inf, no flags. Specials produce no other flags.
- Tag and special decisions are pipelined alongside data.

## Timing
- Latency: 3 cycles from input transfer to out_valid when unstalled; throughput 1 op/cycle.
- Reset (rst_n low, asynchronous): all stage valids = 0, out_valid = 0, result = 0, flags = 0, out_tag = 0. in_ready = 1 after reset since out_valid = 0.
- Reset asserted mid-operation: all in-flight ops are discarded; no output appears after release.
- out_valid && !out_ready: result, flags, out_tag and all stages hold stable; in_ready = 0 the same cycle.
- in_ready is registered-independent: it depends only on out_valid and out_ready, with no path from in_valid.
- Deassertion of out_valid only follows a transfer with nothing valid behind it.

## Test plan
- Basic ops, default format: 0x4188 − 0xC188 (17 − −17) → 0x4208, flags 0. 0x40E0 − 0x4020 (7.0 − 2.5) → 0x4090. 0x3F80 + 0xBF80 → 0x0000, flags 0.
- RNE ties: 0x3F80 + 0x3B80 (1 + 2^-8) → 0x3F80, inexact=1. 0x3F81 + 0x3B80 → 0x3F82, inexact=1.
- Overflow/specials: 0x7F7F + 0x7F7F → 0x7F80, flags 0b0101. 0x7F80 − 0x7F80 → 0x7FC0, flags 0b1000. 0x7FC1 + 0x3F80 → 0x7FC0, invalid. 0x8000 + 0x8000 → 0x8000.
- Underflow/FTZ: 0x0080 − 0x0081 → 0x8000, underflow=1. Subnormal 0x0001 + 0x3F80 → 0x3F80, flags 0.
- Backpressure: issue 6 back-to-back tagged ops with out_ready low for cycles 4–8 → in_ready falls with out_valid, held result stable, all 6 emerge in order with tags intact, none lost or duplicated. Then random stream vs. reference model with random stalls.
- Reset mid-stream: assert rst_n low with 3 ops in flight → outputs 0 immediately, no result after release, next op returns after 3 cycles. Repeat at EXP_W=5, MAN_W=10 (fp16): 0x3C00 + 0x3C00 → 0x4000.
